// File: rtl/omsp_tsc_alarm.sv
// omsp_tsc_alarm: two-channel TSC deadline scheduler with one-shot/periodic
// alarms, pending/overrun status and a shared interrupt on the peripheral bus.
module omsp_tsc_alarm #(
    parameter logic [14:0] BASE_ADDR = 15'h01A0,
    parameter int          DEC_WD    = 4
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    input  logic [63:0] tsc,
    output logic [15:0] per_dout,
    output logic        irq_alarm
);
    logic             sel, wr, rd, ctl_wr, stat_wr;
    logic [2:0]       idx;
    logic [3:0][15:0] cmp;
    logic [1:0][15:0] period;
    logic [1:0]       ie, armed, periodic, pend, ovr, hit;
    logic [15:0]      ctl_rd, stat_rd, rdata;

    assign sel     = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign idx     = per_addr[2:0];
    assign wr      = sel & |per_we;
    assign rd      = sel & ~|per_we;
    assign ctl_wr  = wr & (idx == 3'd4) & &per_we;
    assign stat_wr = wr & (idx == 3'd5) & &per_we;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            cmp    <= '0;
            period <= '0;
            ie     <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr && idx == 3'(i) && per_we[0]) cmp[i][7:0]  <= per_din[7:0];
                if (wr && idx == 3'(i) && per_we[1]) cmp[i][15:8] <= per_din[15:8];
            end
            if (wr && idx[2:1] == 2'b11 && per_we[0]) period[idx[0]][7:0]  <= per_din[7:0];
            if (wr && idx[2:1] == 2'b11 && per_we[1]) period[idx[0]][15:8] <= per_din[15:8];
            if (ctl_wr) ie <= per_din[9:8];
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [63:0] deadline;
        logic [31:0] per_q;
        logic        armed_q, per_mode, pend_q, ovr_q, arm, dis;
        assign dis      = ctl_wr & per_din[2] & (per_din[0] == 1'(c));
        assign arm      = ctl_wr & per_din[1] & ~per_din[2] & (per_din[0] == 1'(c));
        assign hit[c]   = armed_q & (tsc >= deadline);
        assign armed[c] = armed_q;
        assign periodic[c] = per_mode;
        assign pend[c]  = pend_q;
        assign ovr[c]   = ovr_q;
        // A hit always records status, even when the same write disarms or re-arms
        always_ff @(posedge mclk or posedge puc_rst) begin
            if (puc_rst) begin
                deadline <= '0;
                per_q    <= '0;
                armed_q  <= 1'b0;
                per_mode <= 1'b0;
                pend_q   <= 1'b0;
                ovr_q    <= 1'b0;
            end else begin
                if (dis) armed_q <= 1'b0;
                else if (arm) begin
                    deadline <= cmp;
                    per_q    <= period;
                    per_mode <= per_din[3];
                    armed_q  <= 1'b1;
                end else if (hit[c]) begin
                    if (per_mode && per_q != 32'd0) deadline <= deadline + {32'b0, per_q};
                    else armed_q <= 1'b0;
                end
                pend_q <= hit[c] | (pend_q & ~(stat_wr & per_din[c]));
                ovr_q  <= (hit[c] & pend_q) | (ovr_q & ~(stat_wr & per_din[2+c]));
            end
        end
    end

    assign ctl_rd    = {6'b0, ie, 4'b0, periodic, armed};
    assign stat_rd   = {12'b0, ovr, pend};
    assign rdata     = idx[2] ? (idx[1] ? period[idx[0]] : (idx[0] ? stat_rd : ctl_rd)) : cmp[idx[1:0]];
    assign per_dout  = rd ? rdata : 16'h0000;
    assign irq_alarm = |(pend & ie);
endmodule
